// File: rtl/conv_engine_arbiter.sv
// -----------------------------------------------------------------------------
// conv_engine_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters take turns driving one
// convolution engine. A granted job announces itself with eng_start, streams
// its latched number of beats to the engine under valid/ready flow control,
// waits for the engine to report that its pipeline has drained, then pulses
// ack to the owner and moves the round-robin pointer past it.
//
// Ports
//   clk             sole clock, all state on the rising edge
//   rst             synchronous active-high reset
//   req             level request per requester, held until its ack
//   req_len         packed beat counts, requester i at [i*LEN_W +: LEN_W]
//   gnt             one-hot grant, held for the whole job
//   ack             one-hot, one-cycle pulse at job completion
//   eng_start       one-cycle pulse at job start
//   eng_id          index of the granted requester, 0 when idle
//   eng_beat_valid  beat offered to the engine
//   eng_beat_ready  engine accepts the beat
//   eng_last        qualifies the final beat of the job
//   eng_done        engine pipeline drained for the current job
//   busy            high whenever a job is in flight
// -----------------------------------------------------------------------------
module conv_engine_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int LEN_W   = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     eng_start,
    output logic [ID_W-1:0]          eng_id,
    output logic                     eng_beat_valid,
    input  logic                     eng_beat_ready,
    output logic                     eng_last,
    input  logic                     eng_done,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        WAIT,
        ACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [LEN_W-1:0]  beat_cnt;

    logic [ID_W-1:0]   sel_idx;
    logic              sel_found;
    logic [ID_W-1:0]   cand_idx;
    int                cand;

    // Round-robin pick: first set request at or above ptr, wrapping around.
    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path through the block can leave it holding an old value (latch).
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!sel_found && req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. eng_done only matters while waiting for the drain.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_found) state_next = START;
            START:   state_next = (beat_cnt != '0) ? RUN : ACK;
            RUN:     if (eng_beat_ready && (beat_cnt == LEN_W'(1))) state_next = WAIT;
            WAIT:    if (eng_done) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Job datapath: length, owner and fairness pointer. The length is captured
    // only at grant time, so later req_len or req changes cannot disturb a job.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            gnt      <= '0;
            eng_id   <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        beat_cnt <= req_len[sel_idx*LEN_W +: LEN_W];
                        gnt      <= NUM_REQ'(1) << sel_idx;
                        eng_id   <= sel_idx;
                    end
                end
                RUN: begin
                    // eng_beat_valid is high throughout RUN, so ready alone
                    // marks a completed handshake.
                    if (eng_beat_ready) begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                    end
                end
                ACK: begin
                    gnt    <= '0;
                    eng_id <= '0;
                    ptr    <= (int'(eng_id) == NUM_REQ - 1) ? '0 : eng_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign eng_start      = (state == START);
    assign eng_beat_valid = (state == RUN);
    assign eng_last       = (state == RUN) && (beat_cnt == LEN_W'(1));
    assign busy           = (state != IDLE);
    assign ack            = (state == ACK) ? gnt : '0;

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// -----------------------------------------------------------------------------
// tb_conv_engine_arbiter
//
// Directed bench for conv_engine_arbiter (NUM_REQ=4, LEN_W=8). Each job is
// driven through a common task that checks grant, start pulse, beat count,
// eng_last placement, the drain wait, the ack pulse and the return to idle.
// -----------------------------------------------------------------------------
module tb_conv_engine_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic                     eng_start;
    logic [ID_W-1:0]          eng_id;
    logic                     eng_beat_valid;
    logic                     eng_beat_ready;
    logic                     eng_last;
    logic                     eng_done;
    logic                     busy;

    int n_cmp = 0;
    int n_bad = 0;

    int rpat [8];
    int rlen;

    conv_engine_arbiter #(
        .NUM_REQ(NUM_REQ),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_len       (req_len),
        .gnt           (gnt),
        .ack           (ack),
        .eng_start     (eng_start),
        .eng_id        (eng_id),
        .eng_beat_valid(eng_beat_valid),
        .eng_beat_ready(eng_beat_ready),
        .eng_last      (eng_last),
        .eng_done      (eng_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready_all_ones();
        rpat[0] = 1;
        rlen    = 1;
    endtask

    // One complete job starting from IDLE. The caller has set req_len.
    task automatic job(input string tag, input logic [3:0] reqv, input int exp_id,
                       input int len, input bit early, input int done_wait,
                       input bit hold, input bit disturb, input int exp_cycles);
        logic [3:0] oh;
        int beats;
        int cycles;
        int last_bad;
        int wait_bad;
        oh  = 4'b0001 << exp_id;
        req = reqv;
        step();
        check({tag, ":start_gnt"},   32'(gnt),       32'(oh));
        check({tag, ":eng_start"},   32'(eng_start), 32'd1);
        check({tag, ":eng_id"},      32'(eng_id),    32'(exp_id));
        check({tag, ":start_busy"},  32'(busy),      32'd1);
        if (disturb) begin
            req     = '0;
            req_len = {4{8'd7}};
        end
        step();
        beats    = 0;
        cycles   = 0;
        last_bad = 0;
        while (eng_beat_valid && cycles < 1000) begin
            if (eng_last !== ((len - beats) == 1)) last_bad++;
            eng_beat_ready = rpat[cycles % rlen] != 0;
            eng_done       = early && (cycles == 0);
            step();
            if (eng_beat_ready) beats++;
            cycles++;
        end
        eng_beat_ready = 1'b0;
        eng_done       = 1'b0;
        check({tag, ":beats"},      32'(beats),    32'(len));
        check({tag, ":run_cycles"}, 32'(cycles),   32'(exp_cycles));
        check({tag, ":last_pos"},   32'(last_bad), 32'd0);
        if (len > 0) begin
            wait_bad = 0;
            for (int w = 0; w < done_wait; w++) begin
                if (ack !== '0 || busy !== 1'b1 || eng_beat_valid !== 1'b0) wait_bad++;
                step();
            end
            check({tag, ":wait_hold"}, 32'(wait_bad), 32'd0);
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
        end
        check({tag, ":ack"},      32'(ack),            32'(oh));
        check({tag, ":ack_gnt"},  32'(gnt),            32'(oh));
        check({tag, ":ack_vld"},  32'(eng_beat_valid), 32'd0);
        if (!hold) req = '0;
        step();
        check({tag, ":idle_gnt"},  32'(gnt),    32'd0);
        check({tag, ":idle_ack"},  32'(ack),    32'd0);
        check({tag, ":idle_busy"}, 32'(busy),   32'd0);
        check({tag, ":idle_id"},   32'(eng_id), 32'd0);
    endtask

    initial begin
        int fair_ids [6];
        fair_ids = '{3, 0, 1, 2, 3, 0};

        rst            = 1'b1;
        req            = '0;
        req_len        = '0;
        eng_beat_ready = 1'b0;
        eng_done       = 1'b0;
        set_ready_all_ones();
        step();
        step();
        check("rst:gnt",   32'(gnt),            32'd0);
        check("rst:ack",   32'(ack),            32'd0);
        check("rst:start", 32'(eng_start),      32'd0);
        check("rst:id",    32'(eng_id),         32'd0);
        check("rst:valid", 32'(eng_beat_valid), 32'd0);
        check("rst:last",  32'(eng_last),       32'd0);
        check("rst:busy",  32'(busy),           32'd0);
        rst = 1'b0;
        step();

        // Single request, length 3, pointer ends at 3.
        req_len = 32'h0003_0000;
        job("single", 4'b0100, 2, 3, 1'b0, 1, 1'b0, 1'b0, 3);

        // All four requesting: pointer 3 first, then strict rotation.
        req_len = 32'h0101_0101;
        foreach (fair_ids[j]) begin
            job($sformatf("fair%0d", j), 4'b1111, fair_ids[j], 1, 1'b0, 1, 1'b1, 1'b0, 1);
        end
        req = '0;

        // Backpressure with req dropped and req_len changed after the grant.
        rpat[0] = 0; rpat[1] = 1; rpat[2] = 0; rpat[3] = 0; rpat[4] = 1;
        rlen    = 5;
        req_len = 32'h0000_0200;
        job("bp", 4'b0010, 1, 2, 1'b0, 1, 1'b0, 1'b1, 5);
        set_ready_all_ones();

        // Zero-length job: start pulse, no beats, straight to ack.
        req_len = 32'h0000_0000;
        job("len0", 4'b0100, 2, 0, 1'b0, 1, 1'b0, 1'b0, 0);

        // Maximum length.
        req_len = 32'hFF00_0000;
        job("len255", 4'b1000, 3, 255, 1'b0, 1, 1'b0, 1'b0, 255);

        // eng_done during RUN must be ignored; ack waits for a later done.
        req_len = 32'h0000_0001;
        job("early", 4'b0001, 0, 1, 1'b1, 3, 1'b0, 1'b0, 1);

        // Reset after one of four beats: pointer is 1 before the reset.
        req_len        = 32'h0000_0400;
        req            = 4'b0010;
        step();
        check("rstjob:gnt", 32'(gnt), 32'h2);
        step();
        eng_beat_ready = 1'b1;
        step();
        check("rstjob:valid_before", 32'(eng_beat_valid), 32'd1);
        rst = 1'b1;
        step();
        eng_beat_ready = 1'b0;
        req            = '0;
        check("rstjob:gnt0",   32'(gnt),            32'd0);
        check("rstjob:ack0",   32'(ack),            32'd0);
        check("rstjob:start0", 32'(eng_start),      32'd0);
        check("rstjob:id0",    32'(eng_id),         32'd0);
        check("rstjob:valid0", 32'(eng_beat_valid), 32'd0);
        check("rstjob:last0",  32'(eng_last),       32'd0);
        check("rstjob:busy0",  32'(busy),           32'd0);
        rst = 1'b0;
        step();
        check("rstjob:no_ack", 32'(ack), 32'd0);
        req_len = 32'h0101_0101;
        job("post_rst", 4'b1111, 0, 1, 1'b0, 1, 1'b0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
